flipflop_sync: RTL and testbench

FLIPFLOP_SYNC -- requirements
Module: flipflop_sync

---
 rtl/flipflop_sync_pkg.sv | 24 ++
 rtl/flipflop_sync_stage.sv | 49 ++++
 rtl/flipflop_sync.sv | 64 ++++++
 tb/tb_flipflop_sync.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/flipflop_sync_pkg.sv
// ---------------------------------------------------------------------------
// flipflop_sync_pkg
// Shared constants and helpers for the flipflop_sync register pipeline.
//   WIDTH_DEFAULT / WIDTH_MAX   : default and largest supported data width
//   STAGES_DEFAULT / STAGES_MAX : default and largest supported stage count
//   data_max_t                  : widest data word any instance can carry
//   paramsLegal()               : true when a WIDTH/STAGES pair is supported
// ---------------------------------------------------------------------------
package flipflop_sync_pkg;

   localparam int WIDTH_DEFAULT  = 1;
   localparam int WIDTH_MAX      = 64;
   localparam int STAGES_DEFAULT = 1;
   localparam int STAGES_MAX     = 8;

   typedef logic [WIDTH_MAX-1:0] data_max_t;

   // Range check used by the optional embedded assertions.
   function automatic bit paramsLegal(input int width, input int stages);
      return (width >= 1) && (width <= WIDTH_MAX) &&
             (stages >= 1) && (stages <= STAGES_MAX);
   endfunction

endpackage

// File: rtl/flipflop_sync_stage.sv
// ---------------------------------------------------------------------------
// flipflop_sync_stage
// One register stage with synchronous clear and clock enable.
// Priority at each rising edge: clr (load RESET_VALUE) over ena (load d)
// over hold.
// Ports:
//   clk : clock, rising edge active
//   clr : synchronous active-high clear
//   ena : active-high clock enable
//   d   : WIDTH-bit data input
//   q   : WIDTH-bit registered output
// ---------------------------------------------------------------------------
module flipflop_sync_stage
   import flipflop_sync_pkg::*;
#(
   parameter int               WIDTH       = WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stageData_q;
   logic [WIDTH-1:0] stageData_d;

   // Next value when not clearing: take new data only when enabled,
   // otherwise recirculate the current contents.
   always_comb begin
      stageData_d = stageData_q;
      if (ena) begin
         stageData_d = d;
      end
   end

   // Clear is sampled here so it dominates the enable path.
   always_ff @(posedge clk) begin
      if (clr) begin
         stageData_q <= RESET_VALUE;
      end else begin
         stageData_q <= stageData_d;
      end
   end

   assign q = stageData_q;

endmodule

// File: rtl/flipflop_sync.sv
// ---------------------------------------------------------------------------
// flipflop_sync
// Parameterisable pipeline of STAGES registers from d to q sharing one
// synchronous clear and one clock enable, so the whole chain shifts or holds
// as a unit. STAGES=1 is a plain D flip-flop with enable and clear.
// Ports:
//   clk : clock, all state changes on its rising edge
//   clr : synchronous active-high clear, loads RESET_VALUE into every stage
//   ena : active-high clock enable applied to all stages jointly
//   d   : WIDTH-bit data input
//   q   : WIDTH-bit output of the last stage
// Configuration macro:
//   FLIPFLOP_SYNC_CHECK_EN : when defined, embedded assertions check clear
//                            value, hold behaviour and parameter ranges.
// ---------------------------------------------------------------------------
module flipflop_sync
   import flipflop_sync_pkg::*;
#(
   parameter int               WIDTH       = WIDTH_DEFAULT,
   parameter int               STAGES      = STAGES_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ena,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // chain[0] is the input, chain[i+1] is the output of stage i.
   logic [WIDTH-1:0] chain [STAGES+1];

   assign chain[0] = d;

   // Every stage sees the same clr and ena, which keeps the pipeline from
   // ever shifting partially.
   for (genvar i = 0; i < STAGES; i++) begin : gStage
      flipflop_sync_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) uStage (
         .clk (clk),
         .clr (clr),
         .ena (ena),
         .d   (chain[i]),
         .q   (chain[i+1])
      );
   end

   assign q = chain[STAGES];

`ifdef FLIPFLOP_SYNC_CHECK_EN
   // A cleared edge must leave the output at the clear value.
   assertClearValue : assert property (@(posedge clk) clr |=> (q == RESET_VALUE));

   // A non-enabled, non-cleared edge must not move the output.
   assertHold : assert property (@(posedge clk) (!clr && !ena) |=> $stable(q));

   // Parameters must stay inside the supported range.
   assertParams : assert property (@(posedge clk) paramsLegal(WIDTH, STAGES));
`else
`endif

endmodule

// File: tb/tb_flipflop_sync.sv
// ---------------------------------------------------------------------------
// tb_flipflop_sync
// Scoreboard bench for flipflop_sync. Three instances cover the default
// flip-flop, a three-stage pipeline and an 8-bit word with a non-zero clear
// value. Stimulus pushes hand-computed expectations into a queue; a monitor
// pops one entry after each rising edge and compares it with the output of
// the instance it names.
// ---------------------------------------------------------------------------
module tb_flipflop_sync;

   typedef struct {
      int         dutSel;
      logic [7:0] expQ;
      string      name;
   } expect_t;

   logic       clk;
   logic       clr1, ena1, d1, q1;
   logic       clr3, ena3, d3, q3;
   logic       clrW, enaW;
   logic [7:0] dW, qW;

   expect_t    scoreboard[$];
   int         checksTotal;
   int         checksPassed;
   bit         stimDone;

   flipflop_sync #(
      .WIDTH (1), .STAGES (1), .RESET_VALUE (1'b0)
   ) uDutBasic (
      .clk (clk), .clr (clr1), .ena (ena1), .d (d1), .q (q1)
   );

   flipflop_sync #(
      .WIDTH (1), .STAGES (3), .RESET_VALUE (1'b0)
   ) uDutPipe (
      .clk (clk), .clr (clr3), .ena (ena3), .d (d3), .q (q3)
   );

   flipflop_sync #(
      .WIDTH (8), .STAGES (1), .RESET_VALUE (8'hA5)
   ) uDutWide (
      .clk (clk), .clr (clrW), .ena (enaW), .d (dW), .q (qW)
   );

   // 20 ns clock period.
   initial begin
      clk = 1'b0;
      forever begin
         #10 clk = 1'b1;
         #10 clk = 1'b0;
      end
   end

   // Drive one instance at the falling edge and record what its output
   // must be after the following rising edge.
   task automatic applyStimulus(input int dutSel, input logic c, input logic e,
                                input logic [7:0] dv, input logic [7:0] expQ,
                                input string name);
      expect_t item;
      @(negedge clk);
      case (dutSel)
         1: begin clr1 = c; ena1 = e; d1 = dv[0]; end
         3: begin clr3 = c; ena3 = e; d3 = dv[0]; end
         default: begin clrW = c; enaW = e; dW = dv; end
      endcase
      item.dutSel = dutSel;
      item.expQ   = expQ;
      item.name   = name;
      scoreboard.push_back(item);
   endtask

   task automatic checkOutput(input expect_t item);
      logic [7:0] actual;
      case (item.dutSel)
         1:       actual = {7'b0, q1};
         3:       actual = {7'b0, q3};
         default: actual = qW;
      endcase
      checksTotal++;
      if (actual === item.expQ) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: q=%h expected %h", item.name, actual, item.expQ);
      end
   endtask

   // Monitor: sample 1 ns after each rising edge.
   initial begin
      expect_t item;
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) begin
            item = scoreboard.pop_front();
            checkOutput(item);
         end
      end
   end

   initial begin
      clr1 = 1'b1; ena1 = 1'b0; d1 = 1'b0;
      clr3 = 1'b1; ena3 = 1'b0; d3 = 1'b0;
      clrW = 1'b1; enaW = 1'b0; dW = 8'h00;
      checksTotal  = 0;
      checksPassed = 0;
      stimDone     = 1'b0;

      // Plain D flip-flop: clear, clear over enable, hold, load.
      applyStimulus(1, 1'b1, 1'b0, 8'h01, 8'h00, "basic_clr_ena0");
      applyStimulus(1, 1'b1, 1'b1, 8'h01, 8'h00, "basic_clr_over_ena_a");
      applyStimulus(1, 1'b1, 1'b1, 8'h01, 8'h00, "basic_clr_over_ena_b");
      applyStimulus(1, 1'b0, 1'b0, 8'h01, 8'h00, "basic_hold0");
      applyStimulus(1, 1'b0, 1'b1, 8'h00, 8'h00, "basic_load0");
      applyStimulus(1, 1'b0, 1'b1, 8'h01, 8'h01, "basic_load1");
      applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h01, "basic_hold1");
      applyStimulus(1, 1'b1, 1'b0, 8'h01, 8'h00, "basic_clr_from1");

      // Three-stage pipeline: single pulse emerges after three edges.
      applyStimulus(3, 1'b1, 1'b0, 8'h00, 8'h00, "pipe_clr");
      applyStimulus(3, 1'b0, 1'b1, 8'h01, 8'h00, "pipe_lat_e1");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_lat_e2");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h01, "pipe_lat_e3");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_lat_e4");

      // Enable low mid-pipeline freezes every stage together.
      applyStimulus(3, 1'b0, 1'b1, 8'h01, 8'h00, "pipe_hold_load");
      applyStimulus(3, 1'b0, 1'b0, 8'h00, 8'h00, "pipe_hold_a");
      applyStimulus(3, 1'b0, 1'b0, 8'h00, 8'h00, "pipe_hold_b");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_hold_resume");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h01, "pipe_hold_emerge");

      // Clear mid-pipeline: no pre-clear ones may emerge afterwards.
      applyStimulus(3, 1'b0, 1'b1, 8'h01, 8'h00, "pipe_fill_a");
      applyStimulus(3, 1'b0, 1'b1, 8'h01, 8'h00, "pipe_fill_b");
      applyStimulus(3, 1'b1, 1'b1, 8'h01, 8'h00, "pipe_flush");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_after_flush_1");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_after_flush_2");
      applyStimulus(3, 1'b0, 1'b1, 8'h00, 8'h00, "pipe_after_flush_3");

      // 8-bit word with clear value A5.
      applyStimulus(8, 1'b1, 1'b0, 8'h00, 8'hA5, "wide_clr");
      applyStimulus(8, 1'b0, 1'b1, 8'h3C, 8'h3C, "wide_load");
      applyStimulus(8, 1'b0, 1'b0, 8'hFF, 8'h3C, "wide_hold");
      applyStimulus(8, 1'b1, 1'b1, 8'hFF, 8'hA5, "wide_clr_over_ena");
      applyStimulus(8, 1'b0, 1'b1, 8'h5A, 8'h5A, "wide_load2");

      stimDone = 1'b1;
   end

   // Wait for the scoreboard to drain, with a bounded budget.
   initial begin
      int budget;
      budget = 0;
      wait (stimDone);
      while (scoreboard.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      @(negedge clk);
      if (scoreboard.size() > 0) begin
         checksTotal++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
      end
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
